// File: rtl/adc_xyz_scheduler.sv
// Time-multiplexes one ADC front-end across the x, y and z axes and publishes one
// coordinate frame per PERIOD cycles. Build option: ADC_AVG_EN (two conversions per axis, averaged).
module adc_xyz_scheduler #(
  parameter int DATA_W  = 12,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  output logic              adc_start,
  output logic              adc_cs0,
  output logic              adc_cs1,
  output logic              adc_ch_sel,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] z_out,
  output logic              frame_valid,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int CNT_W  = $clog2(PERIOD);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, DONE} state_t;
  typedef enum logic [1:0] {AXIS_X, AXIS_Y, AXIS_Z} axis_t;

  state_t            state;
  state_t            next_state;
  axis_t             axis;
  axis_t             next_axis;
  logic [CNT_W-1:0]  period_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              tick;
  logic              conv_ok;
  logic              conv_timeout;
  logic              conv_end;
  logic              axis_finished;
  logic [DATA_W-1:0] result;

  assign tick         = ena && (period_cnt == CNT_LAST);
  assign conv_ok      = (state == WAIT_DONE) && adc_done;
  assign conv_timeout = (state == WAIT_DONE) && !adc_done && (wait_cnt == WAIT_LAST);
  assign conv_end     = conv_ok || conv_timeout;

`ifdef ADC_AVG_EN
  logic              second;
  logic [DATA_W-1:0] first_sample;
  logic [DATA_W:0]   sum;

  // A timeout on the first conversion abandons the axis instead of trying again.
  assign sum           = {1'b0, first_sample} + {1'b0, adc_data};
  assign result        = DATA_W'(sum >> 1);
  assign axis_finished = second || conv_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      second       <= 1'b0;
      first_sample <= '0;
    end else if (conv_end) begin
      if (conv_ok && !second) begin
        first_sample <= adc_data;
        second       <= 1'b1;
      end else begin
        second <= 1'b0;
      end
    end
  end
`else
  assign result        = adc_data;
  assign axis_finished = 1'b1;
`endif

  always_comb begin
    case (axis)
      AXIS_X:  next_axis = AXIS_Y;
      AXIS_Y:  next_axis = AXIS_Z;
      default: next_axis = AXIS_X;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    next_state  = state;
    adc_start   = 1'b0;
    adc_cs0     = 1'b0;
    adc_cs1     = 1'b0;
    adc_ch_sel  = 1'b0;
    frame_valid = 1'b0;
    overrun     = tick && (state != IDLE);
    case (state)
      IDLE: if (tick) next_state = START;
      START: begin
        adc_start  = 1'b1;
        next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (conv_end) next_state = (axis_finished && axis == AXIS_Z) ? DONE : START;
      end
      DONE: begin
        frame_valid = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (state == START || state == WAIT_DONE) begin
      case (axis)
        AXIS_X: adc_cs0 = 1'b1;
        AXIS_Y: begin
          adc_cs0    = 1'b1;
          adc_ch_sel = 1'b1;
        end
        AXIS_Z:  adc_cs1 = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      axis        <= AXIS_X;
      period_cnt  <= '0;
      wait_cnt    <= '0;
      x_out       <= '0;
      y_out       <= '0;
      z_out       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= next_state;

      if (!ena || tick) period_cnt <= '0;
      else              period_cnt <= period_cnt + 1'b1;

      if (state == START)          wait_cnt <= '0;
      else if (state == WAIT_DONE) wait_cnt <= wait_cnt + 1'b1;

      if (state == IDLE && tick) begin
        axis        <= AXIS_X;
        timeout_err <= 1'b0;
      end
      if (conv_timeout) timeout_err <= 1'b1;
      if (conv_end && axis_finished) axis <= next_axis;

      if (conv_ok && axis_finished) begin
        case (axis)
          AXIS_X:  x_out <= result;
          AXIS_Y:  y_out <= result;
          default: z_out <= result;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_xyz_scheduler.sv
// Randomized bench for adc_xyz_scheduler: a frame timeline model predicts every start
// pulse, select, frame/overrun pulse and register value cycle by cycle.
`timescale 1ns/1ps
module tb_adc_xyz_scheduler;

`ifdef ADC_AVG_EN
  localparam int NCONV  = 2;
  localparam int PERIOD = 28;
  localparam int MAXD   = 1;
`else
  localparam int NCONV  = 1;
  localparam int PERIOD = 16;
  localparam int MAXD   = 2;
`endif
  localparam int DW      = 12;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ena;
  logic          adc_start;
  logic          adc_cs0;
  logic          adc_cs1;
  logic          adc_ch_sel;
  logic          adc_done;
  logic [DW-1:0] adc_data;
  logic [DW-1:0] x_out;
  logic [DW-1:0] y_out;
  logic [DW-1:0] z_out;
  logic          frame_valid;
  logic          timeout_err;
  logic          overrun;

  always #5 clk = ~clk;

  adc_xyz_scheduler #(.DATA_W(DW), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .adc_start  (adc_start),
    .adc_cs0    (adc_cs0),
    .adc_cs1    (adc_cs1),
    .adc_ch_sel (adc_ch_sel),
    .adc_done   (adc_done),
    .adc_data   (adc_data),
    .x_out      (x_out),
    .y_out      (y_out),
    .z_out      (z_out),
    .frame_valid(frame_valid),
    .timeout_err(timeout_err),
    .overrun    (overrun)
  );

  int            cyc;
  int            n_tests;
  int            n_fail;
  int            f_dly[6];
  logic [DW-1:0] f_val[6];
  logic [DW-1:0] m_reg[3];
  logic          m_terr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [2:0] sel_map(input int a);
    case (a)
      0:       return 3'b100;
      1:       return 3'b101;
      2:       return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check_cycle(input logic [5:0] exp_ctl);
    check("ctl", {58'd0, adc_start, frame_valid, overrun, adc_cs0, adc_cs1, adc_ch_sel},
          {58'd0, exp_ctl});
    check("regs", {27'd0, x_out, y_out, z_out, timeout_err},
          {27'd0, m_reg[0], m_reg[1], m_reg[2], m_terr});
  endtask

  task automatic plan_random();
    for (int i = 0; i < 6; i++) begin
      f_dly[i] = $urandom_range(0, MAXD);
      f_val[i] = DW'($urandom);
    end
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      ena      = 1'b0;
      adc_done = 1'($urandom_range(0, 1));
      adc_data = DW'($urandom);
      check_cycle(6'b0);
      @(negedge clk);
      cyc++;
    end
  endtask

  // Plays the converter for one frame whose x start is expected at cycle s0 and checks
  // every cycle up to and including the frame_valid cycle.
  task automatic run_frame(input int s0, input int abort_conv, input bit ena_drop,
                           output int next_s0);
    int            cst[6];
    int            cend[6];
    int            cdc[6];
    int            cax[6];
    logic [DW-1:0] cval[6];
    int            upd_c[3];
    logic [DW-1:0] upd_v[3];
    int            n, t, fv, terr_c, idx, len, m;
    bit            ok, exp_start, exp_fv, exp_ovr, in_wait, drive;
    logic [2:0]    exp_sel;
    logic [DW-1:0] dval;

    n = 0;
    t = s0;
    terr_c = -1;
    for (int a = 0; a < 3; a++) begin
      upd_c[a] = -1;
      upd_v[a] = '0;
      for (int k = 0; k < NCONV; k++) begin
        idx = a * 2 + k;
        ok  = f_dly[idx] < TIMEOUT;
        len = ok ? f_dly[idx] + 2 : TIMEOUT + 1;
        cst[n]  = t;
        cax[n]  = a;
        cdc[n]  = ok ? t + 1 + f_dly[idx] : -1;
        cval[n] = f_val[idx];
        cend[n] = t + len;
        n++;
        t += len;
        if (!ok) begin
          if (terr_c < 0) terr_c = t;
          break;
        end
        if (k == NCONV - 1) begin
          upd_c[a] = t;
          if (NCONV == 1) upd_v[a] = f_val[a * 2];
          else upd_v[a] = DW'((int'(f_val[a * 2]) + int'(f_val[a * 2 + 1])) / 2);
        end
      end
    end
    fv = t;

    m = 1;
    while (s0 + m * PERIOD - 1 <= fv) m++;
    next_s0 = ena_drop ? -1 : s0 + m * PERIOD;

    while (cyc <= fv) begin
      if (abort_conv >= 0 && cyc == cst[abort_conv] + 1) return;
      if (cyc == s0) m_terr = 1'b0;
      if (cyc == terr_c) m_terr = 1'b1;
      for (int a = 0; a < 3; a++) if (cyc == upd_c[a]) m_reg[a] = upd_v[a];

      exp_start = 1'b0;
      exp_sel   = 3'b000;
      in_wait   = 1'b0;
      drive     = 1'b0;
      dval      = '0;
      for (int c = 0; c < n; c++) begin
        if (cyc == cst[c]) exp_start = 1'b1;
        if (cyc >= cst[c] && cyc < cend[c]) exp_sel = sel_map(cax[c]);
        if (cyc > cst[c] && cyc < cend[c]) in_wait = 1'b1;
        if (cyc == cdc[c]) begin
          drive = 1'b1;
          dval  = cval[c];
        end
      end
      exp_fv  = (cyc == fv);
      exp_ovr = !ena_drop && cyc >= s0 && cyc <= fv && ((cyc - s0 + 1) % PERIOD == 0);

      ena = !(ena_drop && cyc > s0);
      if (drive) begin
        adc_done = 1'b1;
        adc_data = dval;
      end else begin
        adc_done = in_wait ? 1'b0 : 1'($urandom_range(0, 1));
        adc_data = DW'($urandom);
      end

      check_cycle({exp_start, exp_fv, exp_ovr, exp_sel});
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int nxt;
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b1;
    ena      = 1'b1;
    adc_done = 1'b0;
    adc_data = '0;
    m_terr   = 1'b0;
    for (int a = 0; a < 3; a++) m_reg[a] = '0;

    @(negedge clk);
    check("rst", {21'd0, adc_start, frame_valid, overrun, adc_cs0, adc_cs1, adc_ch_sel,
                  x_out, y_out, z_out, timeout_err}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    s0    = PERIOD;

    plan_random();
    for (int i = 0; i < 6; i++) f_dly[i] = 0;
`ifdef ADC_AVG_EN
    f_val[0] = 12'h100; f_val[1] = 12'h103;
    f_val[2] = 12'h456; f_val[3] = 12'h456;
    f_val[4] = 12'h789; f_val[5] = 12'h78A;
`else
    f_val[0] = 12'h123; f_val[2] = 12'h456; f_val[4] = 12'h789;
`endif
    run_frame(s0, -1, 1'b0, nxt);
    s0 = nxt;

    repeat (4) begin
      plan_random();
      run_frame(s0, -1, 1'b0, nxt);
      s0 = nxt;
    end

    // y never answers (and, when averaging, z's second conversion too)
    plan_random();
    for (int i = 0; i < 6; i++) f_dly[i] = 0;
    f_dly[2] = TIMEOUT;
    f_dly[5] = TIMEOUT;
    run_frame(s0, -1, 1'b0, nxt);
    s0 = nxt;

    // done arrives on the last permitted wait cycle
    plan_random();
    for (int i = 0; i < 6; i++) f_dly[i] = 0;
    f_dly[2] = TIMEOUT - 1;
    run_frame(s0, -1, 1'b0, nxt);
    s0 = nxt;

    // every conversion times out: the frame outlives its period
    plan_random();
    for (int i = 0; i < 6; i++) f_dly[i] = TIMEOUT;
    run_frame(s0, -1, 1'b0, nxt);
    s0 = nxt;

    plan_random();
    run_frame(s0, -1, 1'b0, nxt);
    s0 = nxt;

    // ena drops right after frame start; the frame still completes
    plan_random();
    run_frame(s0, -1, 1'b1, nxt);
    run_idle(20);
    s0 = cyc + PERIOD;
    plan_random();
    run_frame(s0, -1, 1'b0, nxt);
    s0 = nxt;

    // reset while waiting on y
    plan_random();
    run_frame(s0, NCONV, 1'b0, nxt);
    reset    = 1'b1;
    adc_done = 1'b0;
    @(negedge clk);
    check("rst_mid", {21'd0, adc_start, frame_valid, overrun, adc_cs0, adc_cs1, adc_ch_sel,
                      x_out, y_out, z_out, timeout_err}, 64'd0);
    reset  = 1'b0;
    cyc    = 0;
    m_terr = 1'b0;
    for (int a = 0; a < 3; a++) m_reg[a] = '0;
    s0 = PERIOD;
    plan_random();
    run_frame(s0, -1, 1'b0, nxt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
